datapath: RTL and testbench

- 16-bit processor datapath: 8-entry register file, A/B operand registers, 1-bit shifter on the B path, 4-function ALU, C result register and Z status flag.
- Driven cycle-by-cycle by an external controller/FSM through load, select and write strobes.
- Result leaves on datapath_out, which is the C register.
- Sits between instruction decode/control and memory/IO in the simple CPU.

---
 rtl/datapath_pkg.sv | 24 ++
 rtl/datapath_regfile.sv | 32 +++
 rtl/datapath.sv | 110 +++++++++++
 tb/tb_datapath.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared definitions for the 16-bit CPU datapath.
// Holds the data width, the register-file depth, and the encodings the
// controller drives onto ALUop and shift.
package datapath_pkg;

  localparam int DATA_W   = 16;
  localparam int RF_DEPTH = 8;
  localparam int RF_IDX_W = 3;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_NOT = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_op_e;

endpackage

// File: rtl/datapath_regfile.sv
// 8 x 16 register file with one write port and one combinational read port.
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high clear
//   write, writenum     - write enable and write index
//   data_in             - write data
//   readnum, data_out   - read index and combinational read data
// A read of the entry being written returns the old contents until the edge.
module datapath_regfile
  import datapath_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                write,
  input  logic [RF_IDX_W-1:0] writenum,
  input  logic [DATA_W-1:0]   data_in,
  input  logic [RF_IDX_W-1:0] readnum,
  output logic [DATA_W-1:0]   data_out
);

  logic [DATA_W-1:0] regs [RF_DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RF_DEPTH; i++) regs[i] <= '0;
    end else if (write) begin
      regs[writenum] <= data_in;
    end
  end

  assign data_out = regs[readnum];

endmodule

// File: rtl/datapath.sv
// 16-bit processor datapath: register file, A/B operand registers, a 1-bit
// shifter on the B path, a 4-function ALU, the C result register and the
// Z zero flag. Every strobe comes from an external controller, one cycle
// at a time.
// Ports:
//   clk, reset                 - rising-edge clock, synchronous active-high clear
//   datapath_in                - immediate / external data
//   writenum, write, vsel      - register-file write index, enable, source select
//   readnum                    - register-file read index
//   loada, loadb               - load A / B from the register-file read port
//   asel, bsel                 - ALU operand selects (zero / immediate)
//   shift, ALUop               - shifter and ALU function codes
//   loadc, loads               - load C / Z from the ALU
//   datapath_out, Z_out        - C register and Z flag
module datapath
  import datapath_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   datapath_in,
  input  logic [RF_IDX_W-1:0] writenum,
  input  logic                write,
  input  logic [RF_IDX_W-1:0] readnum,
  input  logic                vsel,
  input  logic                loada,
  input  logic                loadb,
  input  logic                asel,
  input  logic                bsel,
  input  logic [1:0]          shift,
  input  logic [1:0]          ALUop,
  input  logic                loadc,
  input  logic                loads,
  output logic [DATA_W-1:0]   datapath_out,
  output logic                Z_out
);

  logic [DATA_W-1:0] rf_out;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic [DATA_W-1:0] c_reg;
  logic              z_reg;
  logic [DATA_W-1:0] sout;
  logic [DATA_W-1:0] ain;
  logic [DATA_W-1:0] bin;
  logic [DATA_W-1:0] alu_out;

  function automatic logic [DATA_W-1:0] shift_b(input logic [DATA_W-1:0] b,
                                                input logic [1:0] op);
    logic signed [DATA_W-1:0] b_s;
    b_s = b;
    case (shift_op_e'(op))
      SH_NONE: return b;
      SH_LSL:  return {b[DATA_W-2:0], 1'b0};
      SH_LSR:  return {1'b0, b[DATA_W-1:1]};
      SH_ASR:  return b_s >>> 1;
      default: return b;
    endcase
  endfunction

  // All results wrap modulo 2^16; carry and overflow are not reported.
  function automatic logic [DATA_W-1:0] alu_f(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b,
                                              input logic [1:0] op);
    case (alu_op_e'(op))
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_NOT: return ~b;
      default: return a + b;
    endcase
  endfunction

  // Write-back uses the pre-edge C, so a same-cycle loadc does not leak in.
  assign wb_data = vsel ? datapath_in : c_reg;

  datapath_regfile u_regfile (
    .clk      (clk),
    .reset    (reset),
    .write    (write),
    .writenum (writenum),
    .data_in  (wb_data),
    .readnum  (readnum),
    .data_out (rf_out)
  );

  assign sout    = shift_b(b_reg, shift);
  assign ain     = asel ? '0 : a_reg;
  assign bin     = bsel ? datapath_in : sout;
  assign alu_out = alu_f(ain, bin, ALUop);

  // Operand and result registers: each enable acts independently.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg <= '0;
      b_reg <= '0;
      c_reg <= '0;
      z_reg <= 1'b0;
    end else begin
      if (loada) a_reg <= rf_out;
      if (loadb) b_reg <= rf_out;
      if (loadc) c_reg <= alu_out;
      if (loads) z_reg <= (alu_out == '0);
    end
  end

  assign datapath_out = c_reg;
  assign Z_out        = z_reg;

endmodule

// File: tb/tb_datapath.sv
// Directed bench for the CPU datapath: one table row is one controller
// cycle with the C/Z values expected right after that edge.
module tb_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] datapath_in;
  logic [2:0]  writenum;
  logic        write;
  logic [2:0]  readnum;
  logic        vsel, loada, loadb, asel, bsel, loadc, loads;
  logic [1:0]  shift, ALUop;
  logic [15:0] datapath_out;
  logic        Z_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  datapath dut (
    .clk          (clk),
    .reset        (reset),
    .datapath_in  (datapath_in),
    .writenum     (writenum),
    .write        (write),
    .readnum      (readnum),
    .vsel         (vsel),
    .loada        (loada),
    .loadb        (loadb),
    .asel         (asel),
    .bsel         (bsel),
    .shift        (shift),
    .ALUop        (ALUop),
    .loadc        (loadc),
    .loads        (loads),
    .datapath_out (datapath_out),
    .Z_out        (Z_out)
  );

  typedef struct {
    logic [15:0] din;
    logic [2:0]  wn;
    logic        wr;
    logic [2:0]  rn;
    logic        vs, la, lb, as, bs;
    logic [1:0]  sh, op;
    logic        lc, ls;
    logic [15:0] exp_c;
    logic        exp_z;
  } vec_t;

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, AND_ = 2'b10, NOT_ = 2'b11;
  localparam logic [1:0] NONE = 2'b00, LSL = 2'b01, LSR = 2'b10, ASR = 2'b11;

  vec_t vecs [38];

  function automatic vec_t v(input logic [15:0] din, input logic [2:0] wn,
                             input logic wr, input logic [2:0] rn,
                             input logic vs, input logic la, input logic lb,
                             input logic as, input logic bs,
                             input logic [1:0] sh, input logic [1:0] op,
                             input logic lc, input logic ls,
                             input logic [15:0] ec, input logic ez);
    vec_t r;
    r.din = din; r.wn = wn; r.wr = wr; r.rn = rn; r.vs = vs;
    r.la = la; r.lb = lb; r.as = as; r.bs = bs; r.sh = sh; r.op = op;
    r.lc = lc; r.ls = ls; r.exp_c = ec; r.exp_z = ez;
    return r;
  endfunction

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t r);
    datapath_in = r.din; writenum = r.wn; write = r.wr; readnum = r.rn;
    vsel = r.vs; loada = r.la; loadb = r.lb; asel = r.as; bsel = r.bs;
    shift = r.sh; ALUop = r.op; loadc = r.lc; loads = r.ls;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            din      wn wr rn vs la lb as bs sh    op    lc ls  expC     expZ
    // MOV R2=32, R3=42; AND 32&32
    vecs[0]  = v(16'd32,   2, 1, 0, 1, 0, 0, 0, 0, NONE, ADD,  0, 0, 16'd0,   0);
    vecs[1]  = v(16'd42,   3, 1, 0, 1, 0, 0, 0, 0, NONE, ADD,  0, 0, 16'd0,   0);
    vecs[2]  = v(16'd0,    0, 0, 2, 0, 1, 1, 0, 0, NONE, ADD,  0, 0, 16'd0,   0);
    vecs[3]  = v(16'd0,    0, 0, 0, 0, 0, 0, 0, 0, NONE, AND_, 1, 1, 16'd32,  0);
    // ADD R5 = R2 + R3
    vecs[4]  = v(16'd0,    0, 0, 3, 0, 0, 1, 0, 0, NONE, ADD,  0, 0, 16'd32,  0);
    vecs[5]  = v(16'd0,    0, 0, 0, 0, 0, 0, 0, 0, NONE, ADD,  1, 1, 16'd74,  0);
    vecs[6]  = v(16'd0,    5, 1, 0, 0, 0, 0, 0, 0, NONE, ADD,  0, 0, 16'd74,  0);
    vecs[7]  = v(16'd0,    0, 0, 5, 0, 1, 1, 0, 0, NONE, ADD,  0, 0, 16'd74,  0);
    vecs[8]  = v(16'd0,    0, 0, 0, 0, 0, 0, 0, 0, NONE, AND_, 1, 1, 16'd74,  0);
    // R1=2, R0=7: 2 + (7<<1) = 16, written to R2
    vecs[9]  = v(16'd2,    1, 1, 0, 1, 0, 0, 0, 0, NONE, ADD,  0, 0, 16'd74,  0);
    vecs[10] = v(16'd7,    0, 1, 0, 1, 0, 0, 0, 0, NONE, ADD,  0, 0, 16'd74,  0);
    vecs[11] = v(16'd0,    0, 0, 1, 0, 1, 0, 0, 0, NONE, ADD,  0, 0, 16'd74,  0);
    vecs[12] = v(16'd0,    0, 0, 0, 0, 0, 1, 0, 0, NONE, ADD,  0, 0, 16'd74,  0);
    vecs[13] = v(16'd0,    0, 0, 0, 0, 0, 0, 0, 0, LSL,  ADD,  1, 1, 16'd16,  0);
    vecs[14] = v(16'd0,    2, 1, 0, 0, 0, 0, 0, 0, NONE, ADD,  0, 0, 16'd16,  0);
    // 74 - (16>>1) = 66
    vecs[15] = v(16'd0,    0, 0, 5, 0, 1, 0, 0, 0, NONE, ADD,  0, 0, 16'd16,  0);
    vecs[16] = v(16'd0,    0, 0, 2, 0, 0, 1, 0, 0, NONE, ADD,  0, 0, 16'd16,  0);
    vecs[17] = v(16'd0,    0, 0, 0, 0, 0, 0, 0, 0, LSR,  SUB,  1, 1, 16'd66,  0);
    // B = 8002 through each shift, A forced to zero
    vecs[18] = v(16'h8002, 4, 1, 0, 1, 0, 0, 0, 0, NONE, ADD,  0, 0, 16'd66,  0);
    vecs[19] = v(16'd0,    0, 0, 4, 0, 0, 1, 0, 0, NONE, ADD,  0, 0, 16'd66,  0);
    vecs[20] = v(16'd0,    0, 0, 0, 0, 0, 0, 1, 0, ASR,  ADD,  1, 1, 16'hC001, 0);
    vecs[21] = v(16'd0,    0, 0, 0, 0, 0, 0, 1, 0, LSL,  ADD,  1, 1, 16'h0004, 0);
    vecs[22] = v(16'd0,    0, 0, 0, 0, 0, 0, 1, 0, LSR,  ADD,  1, 1, 16'h4001, 0);
    // NOT immediate, then zero result sets Z
    vecs[23] = v(16'd7,    0, 0, 0, 0, 0, 0, 1, 1, NONE, NOT_, 1, 1, 16'hFFF8, 0);
    vecs[24] = v(16'd0,    0, 0, 0, 0, 0, 0, 1, 1, NONE, ADD,  1, 1, 16'h0000, 1);
    // Hold: ALU input changes, no load
    vecs[25] = v(16'd5,    0, 0, 0, 0, 0, 0, 1, 1, NONE, ADD,  0, 0, 16'h0000, 1);
    // FFFF + 2 = 1, FFFF + 1 = 0
    vecs[26] = v(16'hFFFF, 6, 1, 0, 1, 0, 0, 0, 0, NONE, ADD,  0, 0, 16'h0000, 1);
    vecs[27] = v(16'd0,    0, 0, 6, 0, 1, 0, 0, 0, NONE, ADD,  0, 0, 16'h0000, 1);
    vecs[28] = v(16'd2,    0, 0, 0, 0, 0, 0, 0, 1, NONE, ADD,  1, 1, 16'h0001, 0);
    vecs[29] = v(16'd1,    0, 0, 0, 0, 0, 0, 0, 1, NONE, ADD,  1, 1, 16'h0000, 1);
    // 0 - 1 = FFFF; then Z loads alone
    vecs[30] = v(16'd1,    0, 0, 0, 0, 0, 0, 1, 1, NONE, SUB,  1, 1, 16'hFFFF, 0);
    vecs[31] = v(16'd0,    0, 0, 0, 0, 0, 0, 1, 1, NONE, ADD,  0, 1, 16'hFFFF, 1);
    // write R7 from pre-edge C (FFFF) while C loads 9
    vecs[32] = v(16'd9,    7, 1, 0, 0, 0, 0, 1, 1, NONE, ADD,  1, 1, 16'h0009, 0);
    vecs[33] = v(16'd0,    0, 0, 7, 0, 1, 0, 0, 0, NONE, ADD,  0, 0, 16'h0009, 0);
    vecs[34] = v(16'd1,    0, 0, 0, 0, 0, 0, 0, 1, NONE, ADD,  1, 1, 16'h0000, 1);
    // read of R3 during its write sees old value 42
    vecs[35] = v(16'h1234, 3, 1, 3, 1, 0, 1, 0, 0, NONE, ADD,  0, 0, 16'h0000, 1);
    vecs[36] = v(16'd0,    0, 0, 0, 0, 0, 0, 1, 0, NONE, ADD,  1, 1, 16'd42,  0);
    vecs[37] = v(16'd0,    0, 0, 0, 0, 0, 0, 1, 1, NONE, ADD,  0, 1, 16'd42,  1);

    drive(v(16'hABCD, 1, 1, 1, 1, 1, 1, 0, 0, NONE, ADD, 1, 1, 16'd0, 0));
    reset = 1'b1;
    step();
    step();
    check16("reset_c", datapath_out, 16'h0000);
    check1("reset_z", Z_out, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 38; i++) begin
      drive(vecs[i]);
      step();
      check16($sformatf("row%0d_c", i), datapath_out, vecs[i].exp_c);
      check1($sformatf("row%0d_z", i), Z_out, vecs[i].exp_z);
    end

    // Reset wins over simultaneous loadc and write (C=42, Z=1 beforehand)
    drive(v(16'h0055, 1, 1, 0, 1, 1, 1, 1, 1, NONE, ADD, 1, 1, 16'd0, 0));
    reset = 1'b1;
    step();
    reset = 1'b0;
    check16("midreset_c", datapath_out, 16'h0000);
    check1("midreset_z", Z_out, 1'b0);

    // Every register reads back zero: A=B=R[r], ADD -> 0 with Z=1
    for (int r = 0; r < 8; r++) begin
      drive(v(16'h0000, 0, 0, r[2:0], 0, 1, 1, 0, 0, NONE, ADD, 0, 0, 16'd0, 0));
      step();
      drive(v(16'hFFFF, 0, 0, 0, 0, 0, 0, 0, 0, NONE, ADD, 1, 1, 16'd0, 0));
      step();
      check16($sformatf("postreset_r%0d_c", r), datapath_out, 16'h0000);
      check1($sformatf("postreset_r%0d_z", r), Z_out, 1'b1);
      // disturb C/Z so the next register check is meaningful
      drive(v(16'h0003, 0, 0, 0, 0, 0, 0, 1, 1, NONE, ADD, 1, 1, 16'd0, 0));
      step();
      check16($sformatf("imm_r%0d_c", r), datapath_out, 16'h0003);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
